// File: rtl/fft_pkg.sv
// Definitions shared by the SDF FFT stages: index width, the rounding shift
// used by scaled butterflies, and a generic complex sample container.
package fft_pkg;

  localparam int FFT_MAX_W = 32;
  localparam int FFT_RS_W  = FFT_MAX_W + 2;

  typedef struct packed {
    logic signed [FFT_MAX_W-1:0] re;
    logic signed [FFT_MAX_W-1:0] im;
  } cplx_t;

  // Bits needed to count positions 0..2*depth-1 inside a butterfly span.
  function automatic int idx_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Halve with round-half-up; the caller truncates to its output width.
  function automatic logic signed [FFT_RS_W-1:0] round_shift(input logic signed [FFT_RS_W-1:0] x);
    return (x + 34'sd1) >>> 1;
  endfunction

endpackage

// File: rtl/sdf_fb_delay.sv
// Feedback delay line for an SDF stage: DEPTH entries that shift only when
// enabled, so the output is the word written DEPTH enables earlier.
module sdf_fb_delay #(
  parameter int DEPTH = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset; stale words are never emitted.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback FFT stage: butterfly, feedback delay,
// optional 1-bit scaling, valid-gated advance and end-of-stream drain.
module sdf_r2_stage
  import fft_pkg::*;
#(
  parameter  int DEPTH  = 32,
  parameter  int WIDTH  = 16,
  parameter  int SCALE  = 1,
  localparam int OWIDTH = (SCALE != 0) ? WIDTH : WIDTH + 1,
  localparam int IW     = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_re,
  input  logic [WIDTH-1:0]  in_im,
  input  logic              drain,
  output logic              out_valid,
  output logic [OWIDTH-1:0] out_re,
  output logic [OWIDTH-1:0] out_im,
  output logic [IW-1:0]     out_idx
);

  localparam int SW = WIDTH + 2;
  localparam logic [IW-1:0] CNT_LAST = IW'(2*DEPTH-1);
  localparam logic [IW-1:0] CNT_MID  = IW'(DEPTH-1);

  logic [IW-1:0]            cnt_q, cnt_d;
  logic                     pending_q, pending_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OWIDTH-1:0] out_re_q, out_re_d;
  logic signed [OWIDTH-1:0] out_im_q, out_im_d;
  logic [IW-1:0]            out_idx_q, out_idx_d;

  logic                     adv_s, half_s;
  logic signed [WIDTH-1:0]  b_re_s, b_im_s;
  logic signed [OWIDTH-1:0] a_re_s, a_im_s;
  logic signed [SW-1:0]     sum_re_s, sum_im_s, dif_re_s, dif_im_s;
  logic [2*OWIDTH-1:0]      dly_in_s, dly_out_s;

  // Butterfly output mapping: rounded halving when scaled, else full growth.
  function automatic logic signed [OWIDTH-1:0] fscale(input logic signed [SW-1:0] x);
    logic signed [FFT_RS_W-1:0] r;
    logic signed [OWIDTH-1:0]   y;
    if (SCALE != 0) begin
      r = round_shift(FFT_RS_W'(x));
      y = OWIDTH'(r);
    end else begin
      r = FFT_RS_W'(x);
      y = OWIDTH'(x);
    end
    return y;
  endfunction

  sdf_fb_delay #(
    .DEPTH (DEPTH),
    .DW    (2*OWIDTH)
  ) u_delay (
    .clk    (clk),
    .en_i   (adv_s),
    .din_i  (dly_in_s),
    .dout_o (dly_out_s)
  );

  // Operand selection and butterfly sums at WIDTH+2 bits.
  always_comb begin
    adv_s    = in_valid | (drain & pending_q);
    half_s   = cnt_q[IW-1];
    if (in_valid) begin
      b_re_s = in_re;
      b_im_s = in_im;
    end else begin
      b_re_s = {WIDTH{1'b0}};
      b_im_s = {WIDTH{1'b0}};
    end
    {a_re_s, a_im_s} = dly_out_s;
    sum_re_s = SW'(a_re_s) + SW'(b_re_s);
    sum_im_s = SW'(a_im_s) + SW'(b_im_s);
    dif_re_s = SW'(a_re_s) - SW'(b_re_s);
    dif_im_s = SW'(a_im_s) - SW'(b_im_s);
  end

  // Next-state for counter, pending flag, delay input and output registers.
  always_comb begin
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    out_valid_d = 1'b0;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_idx_d   = out_idx_q;
    dly_in_s    = {OWIDTH'(b_re_s), OWIDTH'(b_im_s)};
    if (adv_s) begin
      cnt_d     = (cnt_q == CNT_LAST) ? {IW{1'b0}} : cnt_q + IW'(1);
      out_idx_d = cnt_q;
      if (half_s) begin
        out_valid_d = 1'b1;
        out_re_d    = fscale(sum_re_s);
        out_im_d    = fscale(sum_im_s);
        dly_in_s    = {fscale(dif_re_s), fscale(dif_im_s)};
      end else begin
        out_valid_d = pending_q;
        out_re_d    = a_re_s;
        out_im_d    = a_im_s;
      end
      // A drain advance closing the first half means no second half follows.
      if (cnt_q == CNT_LAST) begin
        pending_d = 1'b1;
      end else if ((cnt_q == CNT_MID) && !in_valid) begin
        pending_d = 1'b0;
      end else begin
        pending_d = pending_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= {IW{1'b0}};
      pending_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= {OWIDTH{1'b0}};
      out_im_q    <= {OWIDTH{1'b0}};
      out_idx_q   <= {IW{1'b0}};
    end else begin
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Bench for sdf_r2_stage: three configurations share one stimulus stream and
// are compared against a span-level reference model every cycle.
module tb_sdf_r2_stage;

  typedef struct {
    bit v;
    int re;
    int im;
    bit dr;
  } stim_t;

  localparam int MD [3] = '{4, 4, 1};
  localparam int MS [3] = '{0, 1, 1};
  localparam int MW [3] = '{9, 8, 8};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_re = 8'd0;
  logic [7:0] in_im = 8'd0;
  logic       drain = 1'b0;

  logic       v0, v1, v2;
  logic [8:0] re0, im0;
  logic [7:0] re1, im1, re2, im2;
  logic [2:0] idx0, idx1;
  logic [0:0] idx2;

  logic [2:0] ov;
  integer     ore [3];
  integer     oim [3];
  integer     oidx [3];

  int checks = 0;
  int failures = 0;

  int  m_pos [3];
  bit  m_pend [3];
  int  m_fb_re [3][4];
  int  m_fb_im [3][4];
  int  m_df_re [3][4];
  int  m_df_im [3][4];
  bit  exp_v [3];
  int  exp_re [3];
  int  exp_im [3];
  int  exp_idx [3];

  stim_t sq[$];
  int g0_re[$], g0_idx[$], g1_re[$], g2_re[$], g2_im[$];

  always #5 clk = ~clk;

  sdf_r2_stage #(.DEPTH(4), .WIDTH(8), .SCALE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .drain(drain), .out_valid(v0), .out_re(re0), .out_im(im0), .out_idx(idx0));
  sdf_r2_stage #(.DEPTH(4), .WIDTH(8), .SCALE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .drain(drain), .out_valid(v1), .out_re(re1), .out_im(im1), .out_idx(idx1));
  sdf_r2_stage #(.DEPTH(1), .WIDTH(8), .SCALE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .drain(drain), .out_valid(v2), .out_re(re2), .out_im(im2), .out_idx(idx2));

  always_comb begin
    ov      = {v2, v1, v0};
    ore[0]  = integer'($signed(re0));
    oim[0]  = integer'($signed(im0));
    ore[1]  = integer'($signed(re1));
    oim[1]  = integer'($signed(im1));
    ore[2]  = integer'($signed(re2));
    oim[2]  = integer'($signed(im2));
    oidx[0] = integer'(idx0);
    oidx[1] = integer'(idx1);
    oidx[2] = integer'(idx2);
  end

  function automatic int wrap(input int x, input int w);
    int y;
    y = x & ((1 << w) - 1);
    if (y >= (1 << (w - 1))) y = y - (1 << w);
    return y;
  endfunction

  // Butterfly result as seen at the output: halved with rounding or full width.
  function automatic int bfly(input int s, input int k);
    if (MS[k] != 0) return wrap((s + 1) >>> 1, MW[k]);
    return wrap(s, MW[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pos[k] = 0; m_pend[k] = 1'b0;
      exp_v[k] = 1'b0; exp_re[k] = 0; exp_im[k] = 0; exp_idx[k] = 0;
      for (int j = 0; j < 4; j++) begin
        m_fb_re[k][j] = 0; m_fb_im[k][j] = 0; m_df_re[k][j] = 0; m_df_im[k][j] = 0;
      end
    end
  endtask

  task automatic add(input bit v, input int re, input int im, input bit dr);
    stim_t s;
    s.v = v; s.re = re; s.im = im; s.dr = dr;
    sq.push_back(s);
  endtask

  task automatic clear_capture();
    sq.delete();
    g0_re.delete(); g0_idx.delete(); g1_re.delete(); g2_re.delete(); g2_im.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_re = 8'd0; in_im = 8'd0; drain = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle and advance the model: first half of a span records the
  // sample and replays the stored difference, second half forms sum/diff.
  task automatic step(input stim_t s);
    logic signed [7:0] r8, i8;
    int xr, xi, j, a_r, a_i;
    @(negedge clk);
    in_valid = s.v; in_re = s.re[7:0]; in_im = s.im[7:0]; drain = s.dr;
    r8 = s.re[7:0]; i8 = s.im[7:0];
    for (int k = 0; k < 3; k++) begin
      if (s.v || (s.dr && m_pend[k])) begin
        xr = s.v ? int'(r8) : 0;
        xi = s.v ? int'(i8) : 0;
        exp_idx[k] = m_pos[k];
        if (m_pos[k] < MD[k]) begin
          exp_v[k]  = m_pend[k];
          exp_re[k] = m_df_re[k][m_pos[k]];
          exp_im[k] = m_df_im[k][m_pos[k]];
          m_fb_re[k][m_pos[k]] = xr;
          m_fb_im[k][m_pos[k]] = xi;
        end else begin
          j = m_pos[k] - MD[k];
          a_r = m_fb_re[k][j];
          a_i = m_fb_im[k][j];
          exp_v[k]  = 1'b1;
          exp_re[k] = bfly(a_r + xr, k);
          exp_im[k] = bfly(a_i + xi, k);
          m_df_re[k][j] = bfly(a_r - xr, k);
          m_df_im[k][j] = bfly(a_i - xi, k);
        end
        if (m_pos[k] == 2*MD[k] - 1) m_pend[k] = 1'b1;
        else if (m_pos[k] == MD[k] - 1 && !s.v) m_pend[k] = 1'b0;
        m_pos[k] = (m_pos[k] + 1) % (2*MD[k]);
      end else begin
        exp_v[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (ov[0] === 1'b1) begin g0_re.push_back(ore[0]); g0_idx.push_back(oidx[0]); end
    if (ov[1] === 1'b1) g1_re.push_back(ore[1]);
    if (ov[2] === 1'b1) begin g2_re.push_back(ore[2]); g2_im.push_back(oim[2]); end
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || ore[k] !== 0 || oim[k] !== 0 || oidx[k] !== 0) begin
        failures++;
        $display("FAIL reset u%0d: got v=%b re=%0d im=%0d idx=%0d, want all zero", k, ov[k], ore[k], oim[k], oidx[k]);
      end
    end
  endtask

  task automatic test_stream();
    int e0 [8] = '{6, 8, 10, 12, -4, -4, -4, -4};
    int e1 [8] = '{3, 4, 5, 6, -2, -2, -2, -2};
    int ei [8] = '{4, 5, 6, 7, 0, 1, 2, 3};
    do_reset();
    clear_capture();
    for (int i = 1; i <= 8; i++) add(1'b1, i, 0, 1'b0);
    for (int i = 0; i < 6; i++) add(1'b0, 0, 0, 1'b1);
    foreach (sq[c]) begin
      step(sq[c]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ov[k] !== exp_v[k] || oidx[k] !== exp_idx[k] ||
            (exp_v[k] && (ore[k] !== exp_re[k] || oim[k] !== exp_im[k]))) begin
          failures++;
          $display("FAIL stream u%0d cyc%0d: got v=%b idx=%0d re=%0d im=%0d, want v=%b idx=%0d re=%0d im=%0d",
                   k, c, ov[k], oidx[k], ore[k], oim[k], exp_v[k], exp_idx[k], exp_re[k], exp_im[k]);
        end
      end
    end
    checks++;
    if (g0_re.size() != 8 || g1_re.size() != 8) begin
      failures++;
      $display("FAIL stream_count: got %0d/%0d valid outputs, want 8/8", g0_re.size(), g1_re.size());
    end
    for (int i = 0; i < 8 && i < g0_re.size() && i < g1_re.size(); i++) begin
      checks++;
      if (g0_re[i] !== e0[i] || g0_idx[i] !== ei[i] || g1_re[i] !== e1[i]) begin
        failures++;
        $display("FAIL stream_seq[%0d]: got s0=%0d idx=%0d s1=%0d, want s0=%0d idx=%0d s1=%0d",
                 i, g0_re[i], g0_idx[i], g1_re[i], e0[i], ei[i], e1[i]);
      end
    end
  endtask

  task automatic test_stall();
    int e0 [8] = '{6, 8, 10, 12, -4, -4, -4, -4};
    int ei [8] = '{4, 5, 6, 7, 0, 1, 2, 3};
    do_reset();
    clear_capture();
    for (int i = 1; i <= 6; i++) add(1'b1, i, 0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 99, 99, 1'b0);
    for (int i = 7; i <= 8; i++) add(1'b1, i, 0, 1'b0);
    for (int i = 0; i < 6; i++) add(1'b0, 0, 0, 1'b1);
    foreach (sq[c]) begin
      step(sq[c]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ov[k] !== exp_v[k] || oidx[k] !== exp_idx[k] ||
            (exp_v[k] && (ore[k] !== exp_re[k] || oim[k] !== exp_im[k]))) begin
          failures++;
          $display("FAIL stall u%0d cyc%0d: got v=%b idx=%0d re=%0d im=%0d, want v=%b idx=%0d re=%0d im=%0d",
                   k, c, ov[k], oidx[k], ore[k], oim[k], exp_v[k], exp_idx[k], exp_re[k], exp_im[k]);
        end
      end
    end
    checks++;
    if (g0_re.size() != 8) begin
      failures++;
      $display("FAIL stall_count: got %0d valid outputs, want 8", g0_re.size());
    end
    for (int i = 0; i < 8 && i < g0_re.size(); i++) begin
      checks++;
      if (g0_re[i] !== e0[i] || g0_idx[i] !== ei[i]) begin
        failures++;
        $display("FAIL stall_seq[%0d]: got re=%0d idx=%0d, want re=%0d idx=%0d", i, g0_re[i], g0_idx[i], e0[i], ei[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e0 [16] = '{6, 8, 10, 12, -4, -4, -4, -4, 22, 24, 26, 28, -4, -4, -4, -4};
    do_reset();
    clear_capture();
    for (int i = 1; i <= 16; i++) add(1'b1, i, 0, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 0, 0, 1'b1);
    foreach (sq[c]) begin
      step(sq[c]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ov[k] !== exp_v[k] || oidx[k] !== exp_idx[k] ||
            (exp_v[k] && (ore[k] !== exp_re[k] || oim[k] !== exp_im[k]))) begin
          failures++;
          $display("FAIL b2b u%0d cyc%0d: got v=%b idx=%0d re=%0d im=%0d, want v=%b idx=%0d re=%0d im=%0d",
                   k, c, ov[k], oidx[k], ore[k], oim[k], exp_v[k], exp_idx[k], exp_re[k], exp_im[k]);
        end
      end
    end
    checks++;
    if (g0_re.size() != 16) begin
      failures++;
      $display("FAIL b2b_count: got %0d valid outputs, want 16", g0_re.size());
    end
    for (int i = 0; i < 16 && i < g0_re.size(); i++) begin
      checks++;
      if (g0_re[i] !== e0[i] || g0_idx[i] !== ((i + 4) % 8)) begin
        failures++;
        $display("FAIL b2b_seq[%0d]: got re=%0d idx=%0d, want re=%0d idx=%0d", i, g0_re[i], g0_idx[i], e0[i], (i + 4) % 8);
      end
    end
  endtask

  task automatic test_async_reset();
    int e0 [8] = '{6, 8, 10, 12, -4, -4, -4, -4};
    do_reset();
    clear_capture();
    for (int i = 1; i <= 6; i++) add(1'b1, i, 0, 1'b0);
    foreach (sq[c]) step(sq[c]);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || ore[k] !== 0 || oim[k] !== 0 || oidx[k] !== 0) begin
        failures++;
        $display("FAIL async_reset u%0d: got v=%b re=%0d im=%0d idx=%0d, want all zero", k, ov[k], ore[k], oim[k], oidx[k]);
      end
    end
    model_reset();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_capture();
    for (int i = 0; i < 5; i++) add(1'b0, 0, 0, 1'b1);
    for (int i = 1; i <= 8; i++) add(1'b1, i, 0, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 0, 0, 1'b1);
    foreach (sq[c]) begin
      step(sq[c]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ov[k] !== exp_v[k] || oidx[k] !== exp_idx[k] ||
            (exp_v[k] && (ore[k] !== exp_re[k] || oim[k] !== exp_im[k]))) begin
          failures++;
          $display("FAIL async u%0d cyc%0d: got v=%b idx=%0d re=%0d im=%0d, want v=%b idx=%0d re=%0d im=%0d",
                   k, c, ov[k], oidx[k], ore[k], oim[k], exp_v[k], exp_idx[k], exp_re[k], exp_im[k]);
        end
      end
    end
    checks++;
    if (g0_re.size() != 8) begin
      failures++;
      $display("FAIL async_count: got %0d valid outputs, want 8", g0_re.size());
    end
    for (int i = 0; i < 8 && i < g0_re.size(); i++) begin
      checks++;
      if (g0_re[i] !== e0[i]) begin
        failures++;
        $display("FAIL async_seq[%0d]: got re=%0d, want re=%0d", i, g0_re[i], e0[i]);
      end
    end
  endtask

  task automatic test_random();
    int x;
    do_reset();
    clear_capture();
    add(1'b1, 127, -127, 1'b0);
    add(1'b1, -128, 128, 1'b0);
    add(1'b0, 0, 0, 1'b1);
    add(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0:       x = 127;
        1:       x = -128;
        default: x = int'($urandom_range(0, 255)) - 128;
      endcase
      add($urandom_range(0, 3) != 0, x, -x, $urandom_range(0, 7) == 0);
    end
    foreach (sq[c]) begin
      step(sq[c]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ov[k] !== exp_v[k] || oidx[k] !== exp_idx[k] ||
            (exp_v[k] && (ore[k] !== exp_re[k] || oim[k] !== exp_im[k]))) begin
          failures++;
          $display("FAIL random u%0d cyc%0d: got v=%b idx=%0d re=%0d im=%0d, want v=%b idx=%0d re=%0d im=%0d",
                   k, c, ov[k], oidx[k], ore[k], oim[k], exp_v[k], exp_idx[k], exp_re[k], exp_im[k]);
        end
      end
    end
    checks++;
    if (g2_re.size() < 2 || g2_re[0] !== 0 || g2_im[0] !== -127 || g2_re[1] !== -128 || g2_im[1] !== 1) begin
      failures++;
      $display("FAIL d1_rounding: got %0d outputs first=(%0d,%0d) second=(%0d,%0d), want (0,-127) (-128,1)",
               g2_re.size(), (g2_re.size() > 0) ? g2_re[0] : 0, (g2_im.size() > 0) ? g2_im[0] : 0,
               (g2_re.size() > 1) ? g2_re[1] : 0, (g2_im.size() > 1) ? g2_im[1] : 0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
